packet_sink: RTL and testbench
==============================

# packet_sink

Terminal consumer for the local port of a NoC switch: accepts flits written by the switch toward its attached node, reassembles them into packets, and checks framing, destination address and length. Paired with the traffic-generating fabric in multi-node benches and at synthesis as a self-checking endpoint. Exposes running packet/flit counters and sticky error flags. A parameterisable backpressure pattern exercises switch stall paths.

## Interface
- DATA_SIZE, 4, payload bits per flit
- ADDR_SIZE, 1, node address width
- ADDR, 0, this node's address
- MAX_PACK_LEN, 10, max flits per packet, head and tail included (≥1)
- READY_PERIOD, 0, 0 = always ready; N ≥ 2 = deassert in_r one cycle in every N
- CNT_SIZE, 16, counter width
- clk  input  1  clock, rising edge
- a_rst  input  1  asynchronous, active-low reset
- data_i  input  DATA_SIZE+2  flit: [DATA_SIZE+1:DATA_SIZE] type, [DATA_SIZE-1:0] payload
- in_w  input  1  upstream has a valid flit on data_i
- in_r  output  1  sink can accept a flit this cycle
- packs_ok  output  CNT_SIZE  well-formed packets received
- flits_cnt  output  CNT_SIZE  all flits accepted
- err_addr  output  1  sticky: head with dest ≠ ADDR
- err_frame  output  1  sticky: body/tail outside a packet, or head inside a packet
- err_len  output  1  sticky: packet exceeded MAX_PACK_LEN
- busy  output  1  mid-packet (state ≠ IDLE)

## Operation
- Flit types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail). Head/single payload[ADDR_SIZE-1:0] = destination.
- Transfer occurs on rising clk when in_w && in_r; no other cycle changes state or counters.
- FSM: IDLE, RECV, DROP.
  - IDLE: head → RECV, len=1; single → packs_ok++ (if dest ok), stay; body/tail → err_frame, stay.
  - RECV: body → len++; tail → packs_ok++ if packet clean, → IDLE; head → err_frame, restart packet with this head (len=1); single → err_frame, process as single, → IDLE.
  - If len would exceed MAX_PACK_LEN: err_len, → DROP.
  - DROP: discard until tail (→ IDLE) or head (err_frame, → RECV, len=1) or single (err_frame, process, → IDLE).
- Address mismatch on head/single sets err_addr; packet is still consumed but not counted in packs_ok.
- flits_cnt increments on every transfer. Counters wrap modulo 2^CNT_SIZE.
- Backpressure: free-running counter 0..READY_PERIOD-1; in_r = 0 when counter = READY_PERIOD-1, else 1. READY_PERIOD = 1 treated as 0.
- Errors sticky until reset.

## Timing
- Reset (a_rst=0): all outputs 0, state IDLE, len 0, stall counter 0; in_r forced 0 asynchronously.
- in_r registered; first 1 on the first rising clk after a_rst deasserts.
- Counters, flags, busy registered: reflect a transfer one cycle after the accepting edge (visible at edge+1).
- Sustained throughput: 1 flit/cycle with READY_PERIOD=0; (N-1)/N otherwise.
- in_w high while in_r low: no transfer, no state change; data_i may change freely.
- Reset asserted mid-packet: packet discarded, no count, no error.

## Structure
- Shared package noc_pkg: flit type encodings (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE), flit field offsets as functions of DATA_SIZE, FSM state encoding.
- Single module; the backpressure counter is small enough to stay inline. No sub-module.

## Test plan
- Reset then head(dest 0), 3 body, tail, READY_PERIOD=0 -> packs_ok=1, flits_cnt=5, no errors, busy high 4 cycles.
- 10 singles dest 0, back to back -> packs_ok=10, flits_cnt=10, in_r never low.
- Head dest 1 + tail at ADDR=0 -> err_addr=1, packs_ok=0, flits_cnt=2.
- Head + 10 body + tail (12 flits, MAX_PACK_LEN=10) -> err_len=1 on 10th-body transfer, DROP until tail, packs_ok=0, next clean packet counted.
- Body while IDLE, then head, head, tail -> err_frame=1, packs_ok=1 (second packet).
- READY_PERIOD=4, in_w held high 40 cycles with bodies inside a long-limit packet -> in_r low exactly every 4th cycle, flits_cnt=30; a_rst pulsed mid-packet -> all outputs 0, in_r low during reset.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: flit type encodings, flit field offsets and sink FSM state encoding
// shared by NoC endpoints.
package noc_pkg;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic int flit_type_lo(input int data_size);
        return data_size;
    endfunction

    function automatic int flit_type_hi(input int data_size);
        return data_size + 1;
    endfunction

endpackage

// File: rtl/packet_sink.sv
// packet_sink: NoC local-port consumer that reassembles flits into packets,
// checks framing/address/length and keeps counters plus sticky error flags.
module packet_sink
    import noc_pkg::*;
#(
    parameter int DATA_SIZE    = 4,
    parameter int ADDR_SIZE    = 1,
    parameter int ADDR         = 0,
    parameter int MAX_PACK_LEN = 10,
    parameter int READY_PERIOD = 0,
    parameter int CNT_SIZE     = 16
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic [DATA_SIZE+1:0] data_i,
    input  logic                 in_w,
    output logic                 in_r,
    output logic [CNT_SIZE-1:0]  packs_ok,
    output logic [CNT_SIZE-1:0]  flits_cnt,
    output logic                 err_addr,
    output logic                 err_frame,
    output logic                 err_len,
    output logic                 busy
);

    localparam int TH = flit_type_hi(DATA_SIZE);
    localparam int TL = flit_type_lo(DATA_SIZE);
    localparam int LW = $clog2(MAX_PACK_LEN + 1) + 1;
    localparam bit BP = READY_PERIOD >= 2;
    localparam int PW = READY_PERIOD > 2 ? $clog2(READY_PERIOD) : 1;
    localparam logic [ADDR_SIZE-1:0] ADDR_V   = ADDR_SIZE'(ADDR);
    localparam logic [PW-1:0]        LAST     = PW'(READY_PERIOD - 1);
    localparam logic [LW-1:0]        LEN_MAX  = LW'(MAX_PACK_LEN);

    state_t          state;
    logic [LW-1:0]   len;
    logic            addr_ok;
    logic [PW-1:0]   stall;
    logic [PW-1:0]   stall_next;
    logic [1:0]      ftype;
    logic            dest_ok;
    logic            xfer;
    logic            len_full;
    logic            unused_payload;

    assign ftype          = data_i[TH:TL];
    assign dest_ok        = data_i[ADDR_SIZE-1:0] == ADDR_V;
    assign xfer           = in_w && in_r;
    assign len_full       = len == LEN_MAX;
    assign stall_next     = stall == LAST ? '0 : stall + 1'b1;
    assign unused_payload = ^data_i;

    // in_r is registered from the next stall count so it drops exactly once per period
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            stall <= '0;
            in_r  <= 1'b0;
        end else if (BP) begin
            stall <= stall_next;
            in_r  <= stall_next != LAST;
        end else begin
            in_r  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state     <= IDLE;
            len       <= '0;
            addr_ok   <= 1'b0;
            packs_ok  <= '0;
            flits_cnt <= '0;
            err_addr  <= 1'b0;
            err_frame <= 1'b0;
            err_len   <= 1'b0;
            busy      <= 1'b0;
        end else if (xfer) begin
            flits_cnt <= flits_cnt + 1'b1;
            if (ftype == FLIT_SINGLE) begin
                if (state != IDLE) err_frame <= 1'b1;
                if (dest_ok) packs_ok <= packs_ok + 1'b1;
                else err_addr <= 1'b1;
                state <= IDLE;
                len   <= '0;
                busy  <= 1'b0;
            end else if (ftype == FLIT_HEAD) begin
                if (state != IDLE) err_frame <= 1'b1;
                if (!dest_ok) err_addr <= 1'b1;
                addr_ok <= dest_ok;
                state   <= RECV;
                len     <= LW'(1);
                busy    <= 1'b1;
            end else if (state == IDLE) begin
                err_frame <= 1'b1;
            end else if (ftype == FLIT_BODY) begin
                if (state == RECV && len_full) begin
                    err_len <= 1'b1;
                    state   <= DROP;
                end else if (state == RECV) begin
                    len <= len + 1'b1;
                end
            end else begin
                // tail that would push the packet past the limit still closes it
                if (state == RECV && len_full) err_len <= 1'b1;
                else if (state == RECV && addr_ok) packs_ok <= packs_ok + 1'b1;
                state <= IDLE;
                len   <= '0;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_sink.sv
// tb_packet_sink: directed self-checking bench for packet_sink, one instance
// always ready (limit 10) and one with a 1-in-4 backpressure pattern.
module tb_packet_sink;

    localparam logic [1:0] HD = 2'b01, BD = 2'b00, TL = 2'b10, SG = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  d0 = '0, d4 = '0;
    logic        w0 = 1'b0, w4 = 1'b0;
    logic        in_r0, in_r4;
    logic [15:0] packs0, flits0, packs4, flits4;
    logic        ea0, ef0, el0, busy0, ea4, ef4, el4, busy4;
    int          n_cmp = 0, n_err = 0;
    int          busy_cyc = 0, rlow0 = 0;

    always #5 clk = ~clk;

    packet_sink #(.DATA_SIZE(4), .ADDR_SIZE(1), .ADDR(0), .MAX_PACK_LEN(10),
                  .READY_PERIOD(0), .CNT_SIZE(16)) u0 (
        .clk(clk), .a_rst(rst_n), .data_i(d0), .in_w(w0), .in_r(in_r0),
        .packs_ok(packs0), .flits_cnt(flits0), .err_addr(ea0), .err_frame(ef0),
        .err_len(el0), .busy(busy0));

    packet_sink #(.DATA_SIZE(4), .ADDR_SIZE(1), .ADDR(0), .MAX_PACK_LEN(63),
                  .READY_PERIOD(4), .CNT_SIZE(16)) u4 (
        .clk(clk), .a_rst(rst_n), .data_i(d4), .in_w(w4), .in_r(in_r4),
        .packs_ok(packs4), .flits_cnt(flits4), .err_addr(ea4), .err_frame(ef4),
        .err_len(el4), .busy(busy4));

    always @(negedge clk) begin
        busy_cyc <= busy_cyc + int'(busy0);
        if (rst_n && !in_r0) rlow0 <= rlow0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s0(input logic [1:0] t, input logic [3:0] p);
        @(negedge clk);
        w0 = 1'b1;
        d0 = {t, p};
    endtask

    task automatic idle0();
        @(negedge clk);
        w0 = 1'b0;
    endtask

    task automatic chk0(input string tag, input int pk, input int fl,
                        input logic ea, input logic ef, input logic el);
        chk({tag, "_packs"}, 32'(packs0), pk);
        chk({tag, "_flits"}, 32'(flits0), fl);
        chk({tag, "_err_addr"}, 32'(ea0), 32'(ea));
        chk({tag, "_err_frame"}, 32'(ef0), 32'(ef));
        chk({tag, "_err_len"}, 32'(el0), 32'(el));
    endtask

    initial begin
        int b0, r0, lows, last, badgap;
        #2;
        chk("rst_in_r0", 32'(in_r0), 0);
        chk("rst_in_r4", 32'(in_r4), 0);
        chk0("rst", 0, 0, 0, 0, 0);
        chk("rst_busy", 32'(busy0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_r_before_edge", 32'(in_r0), 0);
        @(posedge clk);
        #1 chk("in_r_after_edge", 32'(in_r0), 1);

        // head, 3 bodies, tail
        b0 = busy_cyc;
        s0(HD, 4'h0);
        repeat (3) s0(BD, 4'hA);
        s0(TL, 4'h5);
        idle0();
        chk0("pkt5", 1, 5, 0, 0, 0);
        chk("pkt5_busy", 32'(busy0), 0);
        chk("pkt5_busy_cycles", 32'(busy_cyc - b0), 4);

        // ten back-to-back singles
        r0 = rlow0;
        repeat (10) s0(SG, 4'h0);
        idle0();
        chk0("singles", 11, 15, 0, 0, 0);
        chk("singles_in_r_low", 32'(rlow0 - r0), 0);

        // wrong destination
        s0(HD, 4'h1);
        s0(TL, 4'h0);
        idle0();
        chk0("bad_addr", 11, 17, 1, 0, 0);

        // over-long packet: error on the 10th body, dropped until tail
        s0(HD, 4'h0);
        repeat (9) s0(BD, 4'h3);
        s0(BD, 4'h3);
        chk("len_before_limit", 32'(el0), 0);
        s0(TL, 4'h0);
        chk("len_at_limit", 32'(el0), 1);
        chk("len_drop_busy", 32'(busy0), 1);
        idle0();
        chk0("long", 11, 29, 1, 0, 1);
        chk("long_busy", 32'(busy0), 0);
        s0(HD, 4'h0);
        s0(TL, 4'h0);
        idle0();
        chk0("after_long", 12, 31, 1, 0, 1);

        // framing: stray body, then head interrupted by head
        s0(BD, 4'h0);
        s0(HD, 4'h0);
        s0(HD, 4'h0);
        s0(TL, 4'h0);
        idle0();
        chk0("frame", 13, 35, 1, 1, 1);

        // backpressure: in_w held 40 cycles into a long packet
        lows = 0; last = -1; badgap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!in_r4) begin
                lows++;
                if (last >= 0 && i - last != 4) badgap++;
                last = i;
            end
            w4 = 1'b1;
            d4 = {flits4 == 0 ? HD : BD, 4'h0};
        end
        @(negedge clk);
        w4 = 1'b0;
        chk("bp_lows", 32'(lows), 10);
        chk("bp_gaps", 32'(badgap), 0);
        chk("bp_flits", 32'(flits4), 30);
        chk("bp_busy", 32'(busy4), 1);
        chk("bp_packs", 32'(packs4), 0);
        chk("bp_errs", {29'd0, ea4, ef4, el4}, 0);

        // asynchronous reset mid-packet
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_r4", 32'(in_r4), 0);
        chk("arst_in_r0", 32'(in_r0), 0);
        chk("arst_flits4", 32'(flits4), 0);
        chk("arst_busy4", 32'(busy4), 0);
        chk0("arst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0(HD, 4'h0);
        s0(TL, 4'h0);
        idle0();
        chk0("post_rst", 1, 2, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
